// File: rtl/mpu_region_checker.sv
// Memory protection stage between the TileLink A-channel request FIFO and memory.
// Permitted requests are forwarded unchanged; denied ones get a local D response with denied=1.

package mpu_tl_pkg;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [7:0]  source;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
    } tl_a_channel;

    localparam logic [2:0] TL_OP_PUT_FULL = 3'd0;
    localparam logic [2:0] TL_OP_PUT_PART = 3'd1;
    localparam logic [2:0] TL_OP_GET      = 3'd4;

    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

endpackage

module mpu_region_checker
    import mpu_tl_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 32,
    parameter int SRC_W       = 8,
    parameter int REG_IDX_W   = $clog2(NUM_REGIONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  tl_a_channel          req,
    input  logic                 req_avail,
    output logic                 req_pop,
    input  logic                 cfg_we,
    input  logic [REG_IDX_W-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]    cfg_base,
    input  logic [ADDR_W-1:0]    cfg_limit,
    input  logic [1:0]           cfg_perm,
    output tl_a_channel          mem_req,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 d_valid,
    input  logic                 d_ready,
    output logic [2:0]           d_opcode,
    output logic [SRC_W-1:0]     d_source,
    output logic                 d_denied,
    output logic [15:0]          deny_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CHECK   = 2'd1,
        S_FORWARD = 2'd2,
        S_DENY    = 2'd3
    } state_t;

    state_t            state_q;
    tl_a_channel       hold_q;
    logic              mem_valid_q;
    logic              d_valid_q;
    logic              d_denied_q;
    logic [2:0]        d_opcode_q;
    logic [SRC_W-1:0]  d_source_q;
    logic [15:0]       deny_cnt_q;
    logic [15:0]       deny_cnt_d;

    logic [ADDR_W-1:0] base_q  [NUM_REGIONS];
    logic [ADDR_W-1:0] limit_q [NUM_REGIONS];
    logic [1:0]        perm_q  [NUM_REGIONS];

    logic [ADDR_W-1:0]      chk_addr;
    logic                   is_read;
    logic                   is_write;
    logic [NUM_REGIONS-1:0] region_hit;
    logic                   permit;

    // Region table; a write in the CHECK cycle lands after that cycle's decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                base_q[r]  <= '0;
                limit_q[r] <= '0;
                perm_q[r]  <= 2'b00;
            end
        end else if (cfg_we && (int'(cfg_idx) < NUM_REGIONS)) begin
            base_q[cfg_idx]  <= cfg_base;
            limit_q[cfg_idx] <= cfg_limit;
            perm_q[cfg_idx]  <= cfg_perm;
        end
    end

    assign chk_addr = hold_q.address[ADDR_W-1:0];
    assign is_read  = (hold_q.opcode == TL_OP_GET);
    assign is_write = (hold_q.opcode == TL_OP_PUT_FULL) || (hold_q.opcode == TL_OP_PUT_PART);

    // Inverted bounds fail one of the two compares, so such regions never hit.
    always_comb begin
        region_hit = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            region_hit[r] = (base_q[r] <= chk_addr) && (chk_addr <= limit_q[r]) &&
                            ((is_read && perm_q[r][0]) || (is_write && perm_q[r][1]));
        end
    end

    assign permit     = |region_hit;
    assign deny_cnt_d = (deny_cnt_q == 16'hFFFF) ? deny_cnt_q : deny_cnt_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            mem_valid_q <= 1'b0;
            d_valid_q   <= 1'b0;
            d_denied_q  <= 1'b0;
            d_opcode_q  <= 3'd0;
            d_source_q  <= '0;
            deny_cnt_q  <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_avail) begin
                        hold_q  <= req;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (permit) begin
                        mem_valid_q <= 1'b1;
                        state_q     <= S_FORWARD;
                    end else begin
                        d_valid_q  <= 1'b1;
                        d_denied_q <= 1'b1;
                        d_opcode_q <= is_read ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
                        d_source_q <= hold_q.source[SRC_W-1:0];
                        deny_cnt_q <= deny_cnt_d;
                        state_q    <= S_DENY;
                    end
                end
                S_FORWARD: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_DENY: begin
                    if (d_ready) begin
                        d_valid_q  <= 1'b0;
                        d_denied_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The pop strobe must fall with reset even though state is already IDLE.
    assign req_pop    = (state_q == S_IDLE) && req_avail && !rst;
    assign busy       = (state_q != S_IDLE);
    assign mem_req    = hold_q;
    assign mem_valid  = mem_valid_q;
    assign d_valid    = d_valid_q;
    assign d_denied   = d_denied_q;
    assign d_opcode   = d_opcode_q;
    assign d_source   = d_source_q;
    assign deny_count = deny_cnt_q;

    a_one_response: assert property (@(posedge clk) disable iff (rst)
        !(mem_valid && d_valid));

    a_mem_hold: assert property (@(posedge clk) disable iff (rst)
        (mem_valid && !mem_ready) |=> (mem_valid && $stable(mem_req)));

    a_d_hold: assert property (@(posedge clk) disable iff (rst)
        (d_valid && !d_ready) |=> (d_valid && $stable(d_source) && $stable(d_opcode)));

endmodule

// File: doc/mpu_region_checker.md
# mpu_region_checker

Protection stage directly downstream of the TileLink A-channel request FIFO. Pops one request at a time from the FIFO head and checks its address and opcode against a programmable table of protection regions. Permitted requests are forwarded unchanged to the memory-side A channel. Denied requests are answered locally with a TileLink D-channel response carrying `denied=1` and are never forwarded.

## Interface
- `NUM_REGIONS`, 4: number of protection regions (2..16).
- `ADDR_W`, 32: width of the address compared, taken from `req.address[ADDR_W-1:0]`.
- `SRC_W`, 8: width of the source field, taken from `req.source[SRC_W-1:0]`.
- `REG_IDX_W`, `$clog2(NUM_REGIONS)`: width of the region index.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  tl_a_channel  head entry of the request FIFO; valid when `req_avail`=1.
- `req_avail`  in  1  FIFO non-empty (the FIFO chip-select).
- `req_pop`  out  1  one-cycle dequeue strobe to the FIFO.
- `cfg_we`  in  1  region table write strobe.
- `cfg_idx`  in  REG_IDX_W  region written.
- `cfg_base`, `cfg_limit`  in  ADDR_W  inclusive region bounds.
- `cfg_perm`  in  2  bit0 = read allowed, bit1 = write allowed; `2'b00` disables the region.
- `mem_req`  out  tl_a_channel  forwarded request.
- `mem_valid`  out  1  forwarded request valid.
- `mem_ready`  in  1  memory accepts the forwarded request.
- `d_valid`  out  1  deny response valid.
- `d_ready`  in  1  deny response accepted.
- `d_opcode`  out  3  AccessAck (0) or AccessAckData (1).
- `d_source`  out  SRC_W  source of the denied request.
- `d_denied`  out  1  constant 1 while `d_valid`=1, else 0.
- `deny_count`  out  16  saturating count of denied requests.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, CHECK, FORWARD, DENY.
- IDLE:
  - If `req_avail`=1: latch `req` into a holding register, pulse `req_pop` for that cycle, go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (exactly one cycle): classify the held request and register the result.
  - Read: opcode 4 (Get).
  - Write: opcode 0 (PutFullData) or opcode 1 (PutPartialData).
  - Any other opcode is denied.
- Region match:
  - A region matches when `base <= addr <= limit` (unsigned, full ADDR_W) and its perm bit for the access type is 1.
  - Regions with `base > limit` never match.
  - Any matching region permits the request; no match denies it.
- Permitted: go to FORWARD. Denied: go to DENY, `deny_count` += 1, saturating at 16'hFFFF.
- FORWARD:
  - `mem_valid`=1 and `mem_req` = held request, held stable until `mem_ready`=1.
  - On the `mem_ready` cycle: go to IDLE.
- DENY:
  - `d_valid`=1, `d_denied`=1, `d_source` = held source.
  - `d_opcode` = 1 for a Get, 0 for anything else.
  - Held stable until `d_ready`=1, then go to IDLE.
- Region table:
  - `cfg_we` writes entry `cfg_idx` at the clock edge; a write to an out-of-range index is ignored.
  - The new value is visible to a CHECK in the next cycle or later.
  - A write landing in the same cycle as CHECK does not affect that CHECK.
- At most one request is in flight; no new pop until the current request completes.

## Timing
- Reset values:
  - State = IDLE.
  - `req_pop`, `mem_valid`, `d_valid`, `d_denied`, `busy` = 0.
  - `mem_req` = '0, `d_opcode` = 0, `d_source` = 0, `deny_count` = 0.
  - All regions: base = 0, limit = 0, perm = 00, so every request is denied.
- Latency with FIFO non-empty and downstream ready:
  - Pop at cycle 0, CHECK at cycle 1, `mem_valid`/`d_valid` asserted from cycle 2.
  - Earliest next pop at cycle 3.
  - Throughput is one request per 3 cycles at best.
- `req_pop` is never asserted while `busy`=1 or while `req_avail`=0.
- `mem_valid` and `d_valid` are never both 1.
- Valid outputs never deassert before their handshake completes.
- Reset asserted mid-operation:
  - Immediate return to the reset values, and the held request is dropped.
  - `deny_count` and the region table are cleared.
- Downstream ready asserted before valid has no effect.

## Test plan
- Reset only, then push Get @0x100 → DENY at cycle 2; `d_opcode`=1, `d_denied`=1, `d_source` matches the request, `deny_count`=1, no `mem_valid`.
- Program region 0 = [0x1000,0x1FFF] perm 01; Get @0x1FFF → forwarded. PutFullData @0x1800 → denied with `d_opcode`=0. Get @0x2000 → denied.
- Overlapping regions: region 1 = [0x0,0xFFFF] perm 10 and region 2 = [0x8000,0x8FFF] perm 01; Get @0x8004 → forwarded, Put @0x8004 → forwarded, Get @0x100 → denied.
- Back-pressure: hold `mem_ready`=0 for 5 cycles with 3 requests queued → `mem_req` stable, exactly one `req_pop` until the handshake, then pops resume.
- Opcode 6 (Acquire-type) to a fully permitted region → denied; `deny_count` preloaded near 0xFFFF saturates at 0xFFFF.
- Reset pulse during FORWARD → `mem_valid` drops asynchronously, state returns to IDLE, and the next request is denied because the table is cleared.
